// File: rtl/axi_arbiter_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// axi_arbiter_if -- AXI-Lite bundle (AR, R, AW, W, B) shared by both masters
// and the memory-side port of axi_arbiter.
//
// Parameters
//   ADDR_W : address width of the AR/AW channels
//   DATA_W : data width of R/W; the write strobe is DATA_W/8 bits
//
// Modports
//   master : drives ar*/aw*/w* valid+payload, rready, bready
//   slave  : drives arready, r*, awready, wready, b*
// ---------------------------------------------------------------------------
interface axi_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Read address / read data
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  // Write address / write data / write response
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, rready,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// axi_arbiter -- two-master to one-slave AXI-Lite arbiter.
//
// Master 0 (IFU) issues reads only; master 1 (LSU) issues reads and writes.
// Exactly one transaction is outstanding at a time. A request seen in IDLE is
// granted on that clock edge and forwarded combinationally from the next
// cycle; completion of the response returns the FSM to IDLE for at least one
// cycle before the next grant.
//
// Ports
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous, active-high reset
//   ifu  : IFU master (slave modport; only AR/R are used, AW/W/B tied off)
//   lsu  : LSU master (slave modport; AR/R/AW/W/B)
//   s    : memory-side port (master modport)
//
// Configuration
//   ARB_ROUND_ROBIN_EN : when defined, IFU/LSU contention is resolved by a
//                        1-bit last-grant pointer favouring the master not
//                        served last. When undefined, the LSU always wins.
//                        A simultaneous LSU write and read always picks the
//                        write first in both modes.
// ---------------------------------------------------------------------------
module axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  axi_arbiter_if.slave  ifu,
  axi_arbiter_if.slave  lsu,
  axi_arbiter_if.master s
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } state_t;

  state_t r_state;
  logic   r_ar_done;   // AR handed to the slave in the current read
  logic   r_aw_done;   // AW handshake completed in the current write
  logic   r_w_done;    // W handshake completed in the current write
`ifdef ARB_ROUND_ROBIN_EN
  logic   r_last_lsu;  // 1: LSU was served last, 0: IFU was served last
`endif

  // Grant selection
  logic   w_lsu_req;
  logic   w_pick_lsu;
  state_t w_grant;

  // Forwarded handshake signals
  logic [ADDR_W-1:0]   w_s_araddr;
  logic                w_s_arvalid;
  logic                w_s_rready;
  logic [ADDR_W-1:0]   w_s_awaddr;
  logic                w_s_awvalid;
  logic [DATA_W-1:0]   w_s_wdata;
  logic [DATA_W/8-1:0] w_s_wstrb;
  logic                w_s_wvalid;
  logic                w_s_bready;
  logic                w_ifu_arready;
  logic                w_ifu_rvalid;
  logic                w_lsu_arready;
  logic                w_lsu_rvalid;
  logic                w_lsu_awready;
  logic                w_lsu_wready;
  logic                w_lsu_bvalid;

  // Handshake events
  logic w_ar_fire;
  logic w_aw_fire;
  logic w_w_fire;
  logic w_b_fire;
  logic w_ifu_r_fire;
  logic w_lsu_r_fire;
  logic w_rd_abandon;
  logic w_wr_abandon;

  // The IFU never writes; its write-side inputs are intentionally ignored.
  logic w_ifu_wr_unused;
  assign w_ifu_wr_unused = ^{ifu.awaddr, ifu.awvalid, ifu.wdata, ifu.wstrb,
                             ifu.wvalid, ifu.bready};

  // -------------------------------------------------------------------------
  // Arbitration: which state the FSM enters from IDLE this edge.
  // -------------------------------------------------------------------------
  assign w_lsu_req = lsu.arvalid | lsu.awvalid;

`ifdef ARB_ROUND_ROBIN_EN
  // On contention the LSU wins only if the IFU was served last.
  assign w_pick_lsu = w_lsu_req & (~ifu.arvalid | ~r_last_lsu);
`else
  assign w_pick_lsu = w_lsu_req;
`endif

  always_comb begin
    w_grant = IDLE;
    if (w_pick_lsu) begin
      w_grant = lsu.awvalid ? LSU_WR : LSU_RD;
    end else if (ifu.arvalid) begin
      w_grant = IFU_RD;
    end
  end

  // -------------------------------------------------------------------------
  // Channel forwarding. Everything is low in IDLE and while rst is high, so
  // a reset mid-transaction silences both sides immediately.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the case so that paths not
    // listed in a state fall back to 0 instead of inferring a latch.
    w_s_araddr    = '0;
    w_s_arvalid   = 1'b0;
    w_s_rready    = 1'b0;
    w_s_awaddr    = '0;
    w_s_awvalid   = 1'b0;
    w_s_wdata     = '0;
    w_s_wstrb     = '0;
    w_s_wvalid    = 1'b0;
    w_s_bready    = 1'b0;
    w_ifu_arready = 1'b0;
    w_ifu_rvalid  = 1'b0;
    w_lsu_arready = 1'b0;
    w_lsu_rvalid  = 1'b0;
    w_lsu_awready = 1'b0;
    w_lsu_wready  = 1'b0;
    w_lsu_bvalid  = 1'b0;
    if (!rst) begin
      case (r_state)
        IFU_RD: begin
          w_s_araddr    = ifu.araddr;
          w_s_arvalid   = ifu.arvalid;
          w_ifu_arready = s.arready;
          w_ifu_rvalid  = s.rvalid;
          w_s_rready    = ifu.rready;
        end
        LSU_RD: begin
          w_s_araddr    = lsu.araddr;
          w_s_arvalid   = lsu.arvalid;
          w_lsu_arready = s.arready;
          w_lsu_rvalid  = s.rvalid;
          w_s_rready    = lsu.rready;
        end
        LSU_WR: begin
          // AW and W complete independently; each is masked once accepted so
          // the slave sees exactly one beat per channel.
          w_s_awaddr    = lsu.awaddr;
          w_s_awvalid   = lsu.awvalid & ~r_aw_done;
          w_lsu_awready = s.awready & ~r_aw_done;
          w_s_wdata     = lsu.wdata;
          w_s_wstrb     = lsu.wstrb;
          w_s_wvalid    = lsu.wvalid & ~r_w_done;
          w_lsu_wready  = s.wready & ~r_w_done;
          w_lsu_bvalid  = s.bvalid;
          w_s_bready    = lsu.bready;
        end
        default: ;
      endcase
    end
  end

  assign w_ar_fire    = w_s_arvalid & s.arready;
  assign w_aw_fire    = w_s_awvalid & s.awready;
  assign w_w_fire     = w_s_wvalid & s.wready;
  assign w_b_fire     = w_lsu_bvalid & lsu.bready;
  assign w_ifu_r_fire = w_ifu_rvalid & ifu.rready;
  assign w_lsu_r_fire = w_lsu_rvalid & lsu.rready;

  // A master that withdraws its request before anything reached the slave
  // would otherwise park the FSM forever; fall back to IDLE instead.
  assign w_rd_abandon = ~r_ar_done & ~w_s_arvalid;
  assign w_wr_abandon = ~r_aw_done & ~r_w_done & ~lsu.awvalid & ~lsu.wvalid;

  // -------------------------------------------------------------------------
  // State machine
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state    <= IDLE;
      r_ar_done  <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_lsu <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_state   <= w_grant;
          r_ar_done <= 1'b0;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end
        IFU_RD: begin
          if (w_ar_fire) r_ar_done <= 1'b1;
          if (w_ifu_r_fire || w_rd_abandon) begin
            r_state <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_lsu <= 1'b0;
`endif
          end
        end
        LSU_RD: begin
          if (w_ar_fire) r_ar_done <= 1'b1;
          if (w_lsu_r_fire || w_rd_abandon) begin
            r_state <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_lsu <= 1'b1;
`endif
          end
        end
        LSU_WR: begin
          if (w_aw_fire) r_aw_done <= 1'b1;
          if (w_w_fire)  r_w_done  <= 1'b1;
          if (w_b_fire || w_wr_abandon) begin
            r_state   <= IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_lsu <= 1'b1;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Port hookup. Response payloads pass through untouched; only the valid
  // and ready qualifiers are steered.
  // -------------------------------------------------------------------------
  assign s.araddr  = w_s_araddr;
  assign s.arvalid = w_s_arvalid;
  assign s.rready  = w_s_rready;
  assign s.awaddr  = w_s_awaddr;
  assign s.awvalid = w_s_awvalid;
  assign s.wdata   = w_s_wdata;
  assign s.wstrb   = w_s_wstrb;
  assign s.wvalid  = w_s_wvalid;
  assign s.bready  = w_s_bready;

  assign ifu.arready = w_ifu_arready;
  assign ifu.rvalid  = w_ifu_rvalid;
  assign ifu.rdata   = s.rdata;
  assign ifu.rresp   = s.rresp;
  assign ifu.awready = 1'b0;
  assign ifu.wready  = 1'b0;
  assign ifu.bvalid  = 1'b0;
  assign ifu.bresp   = 2'b00;

  assign lsu.arready = w_lsu_arready;
  assign lsu.rvalid  = w_lsu_rvalid;
  assign lsu.rdata   = s.rdata;
  assign lsu.rresp   = s.rresp;
  assign lsu.awready = w_lsu_awready;
  assign lsu.wready  = w_lsu_wready;
  assign lsu.bvalid  = w_lsu_bvalid;
  assign lsu.bresp   = s.bresp;

endmodule

// File: doc/axi_arbiter.md
AXI_ARBITER -- requirements
Module: axi_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of every channel.
REQ-002 SHALL have parameter DATA_W, default 32, data width; strobe width is DATA_W/8.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ifu_araddr/ifu_arvalid/ifu_arready, in/in/out, ADDR_W/1/1, the IFU read-address channel (master 0).
REQ-006 SHALL have ifu_rdata/ifu_rresp/ifu_rvalid/ifu_rready, out/out/out/in, DATA_W/2/1/1, the IFU read-data channel.
REQ-007 SHALL have lsu_araddr/lsu_arvalid/lsu_arready, in/in/out, ADDR_W/1/1, the LSU read-address channel (master 1).
REQ-008 SHALL have lsu_rdata/lsu_rresp/lsu_rvalid/lsu_rready, out/out/out/in, DATA_W/2/1/1, the LSU read-data channel.
REQ-009 SHALL have lsu_awaddr/lsu_awvalid/lsu_awready, in/in/out, ADDR_W/1/1, the LSU write-address channel.
REQ-010 SHALL have lsu_wdata/lsu_wstrb/lsu_wvalid/lsu_wready, in/in/in/out, DATA_W/DATA_W/8/1/1, the LSU write-data channel.
REQ-011 SHALL have lsu_bresp/lsu_bvalid/lsu_bready, out/out/in, 2/1/1, the LSU write-response channel.
REQ-012 SHALL have s_ar*, s_r*, s_aw*, s_w*, s_b* with the same names, widths and opposite directions, the single AXI-Lite slave-side port to memory.

Function
REQ-013 SHALL use a state machine with states IDLE, IFU_RD, LSU_RD, LSU_WR; only one transaction is outstanding at any time.
REQ-014 In IDLE, SHALL drive every arready/awready/wready/rvalid/bvalid (both sides) low and sample ifu_arvalid, lsu_arvalid, lsu_awvalid.
REQ-015 Grant SHALL be registered: requests seen in IDLE at edge N enter the granted state at edge N, and forwarding begins cycle N+1 (one-cycle arbitration latency).
REQ-016 For an LSU simultaneous write and read request, SHALL grant the write (LSU_WR) first.
REQ-017 Between IFU and LSU, SHALL grant the LSU in fixed-priority mode (see REQ-028).
REQ-018 In IFU_RD/LSU_RD, SHALL connect the granted master's AR and R channels combinationally to s_ar*/s_r*; the other master sees arready=0, rvalid=0.
REQ-019 In LSU_WR, SHALL connect AW, W and B combinationally; aw and w may complete in any order or the same cycle, tracked by aw_done and w_done flags; s_awvalid/s_wvalid are masked once their own flag is set.
REQ-020 SHALL return to IDLE on the edge where s_rvalid&granted rready (read) or s_bvalid&lsu_bready (write) is high; no back-to-back grant without one IDLE cycle.
REQ-021 Slave s_ar*/s_aw*/s_w* outputs SHALL be valid-low whenever not granted; addresses and data are don't-care then.
REQ-022 rresp/bresp SHALL be passed through unchanged, including error responses; the arbiter never generates responses itself.
REQ-023 A master deasserting valid before handshake is a protocol violation; behaviour then is undefined except that the FSM never deadlocks after reset.

Reset
REQ-024 While rst is high, SHALL force state IDLE, clear aw_done, w_done and the round-robin pointer, and drive all valid/ready outputs low.
REQ-025 Reset asserted mid-transaction SHALL abandon it; the slave is assumed reset by the same rst.
REQ-026 After rst deasserts, the first grant SHALL occur no earlier than the first cycle with rst low.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN SHALL select the IFU/LSU arbitration policy.
REQ-028 Without ARB_ROUND_ROBIN_EN: LSU always wins over IFU on simultaneous requests.
REQ-029 With ARB_ROUND_ROBIN_EN: a 1-bit last-grant pointer favours the master not served last; pointer updates on each return to IDLE; REQ-016 still holds within the LSU.

Verification
REQ-030 IFU read 0x8000_0000 alone, slave returns 0x0000_0413 after 3 cycles -> ifu_rvalid with 0x0000_0413, lsu_rvalid stays 0, FSM back to IDLE next edge.
REQ-031 IFU read and LSU read 0x8000_1000 same cycle, no macro -> LSU served first, IFU second; with ARB_ROUND_ROBIN_EN and last grant LSU -> IFU first.
REQ-032 LSU write 0xDEADBEEF strb 4'b0011 to 0x8000_2000, W handshake 2 cycles before AW -> slave sees each exactly once, lsu_bvalid once, bresp 2'b00.
REQ-033 LSU awvalid and arvalid together -> write completes before s_arvalid rises.
REQ-034 rst pulsed during LSU_RD with s_rvalid pending -> all valids low next cycle, state IDLE, new IFU request granted normally.
REQ-035 Slave returns rresp 2'b10 on IFU read -> ifu_rresp 2'b10 passed through, arbiter returns to IDLE.
